mult4u_redundant_sched: RTL and testbench

- Sequencer and arbiter that shares one combinational 4x4 unsigned multiplier between NREQ requesters.
- Each product is computed twice by temporal redundancy: pass 1 drives A*B, pass 2 drives the swapped operands B*A. The two results are compared.
- On mismatch the operation is retried, up to MAX_RETRY times. After that the response carries an error flag.
- Sits between requester logic and the multiplier instance. Also keeps saturating fault statistics.

---
 rtl/mult_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mult4u_redundant_sched.sv | 156 +++++++++++++++
 tb/tb_mult4u_redundant_sched.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the redundant multiplier scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_sched_pkg;

  localparam int W_DEFAULT     = 4;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN1 = 3'd1,
    RUN2 = 3'd2,
    CMP  = 3'd3,
    RESP = 3'd4
  } state_t;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is asserted.
module rr_arbiter #(
  parameter int  NREQ = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  localparam logic [IDW:0] NREQ_L = (IDW + 1)'(NREQ);

  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;

  // Rotate so the pointer slot sits at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDW-1:0];
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_L) sum = sum - NREQ_L;
    grant_idx = sum[IDW-1:0];
    grant     = '0;
    if (|req) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/mult4u_redundant_sched.sv
// Shares one combinational WxW multiplier among NREQ requesters; each product is taken as A*B then B*A and compared, with retries.
// Latency: rsp_valid 4 cycles after accept on a clean compare, +3 per retry, at most 4+3*MAX_RETRY.
// Backpressure: response fields hold until rsp_ready; nothing new is accepted until the response is taken.
module mult4u_redundant_sched
  import mult_sched_pkg::*;
#(
  parameter int  W         = W_DEFAULT,
  parameter int  NREQ      = 2,
  parameter int  MAX_RETRY = 2,
  parameter int  CNT_W     = CNT_W_DEFAULT,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mult_a,
  output logic [W-1:0]      mult_b,
  input  logic [2*W-1:0]    mult_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_prod,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  stat_mismatch,
  output logic [CNT_W-1:0]  stat_err
);

  localparam int             RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);
  localparam logic [31:0]    CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [RW-1:0]   retry;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [2*W-1:0]  p1;
  logic [2*W-1:0]  p2;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            accept;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is only offered while idle; reset forces it low so every output reads 0 during reset.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept    = (state == IDLE) && (|req_valid);

  // Pick the winning requester's operand slices.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Sequencer: accept, two swapped passes, compare, retry or respond; multiplier inputs are parked at 0 outside the passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      cur_id        <= '0;
      retry         <= '0;
      op_a          <= '0;
      op_b          <= '0;
      p1            <= '0;
      p2            <= '0;
      mult_a        <= '0;
      mult_b        <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_prod      <= '0;
      rsp_err       <= 1'b0;
      stat_mismatch <= '0;
      stat_err      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= grant_idx;
            retry  <= '0;
            ptr    <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
            mult_a <= sel_a;
            mult_b <= sel_b;
            state  <= RUN1;
          end
        end
        RUN1: begin
          p1     <= mult_p;
          mult_a <= op_b;
          mult_b <= op_a;
          state  <= RUN2;
        end
        RUN2: begin
          p2     <= mult_p;
          mult_a <= '0;
          mult_b <= '0;
          state  <= CMP;
        end
        CMP: begin
          if (p1 == p2) begin
            rsp_id    <= cur_id;
            rsp_prod  <= p1;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            stat_mismatch <= CNT_W'(sat_inc(32'(stat_mismatch), CNT_MAX));
            if (retry < RETRY_LIM) begin
              retry  <= retry + 1'b1;
              mult_a <= op_a;
              mult_b <= op_b;
              state  <= RUN1;
            end else begin
              stat_err  <= CNT_W'(sat_inc(32'(stat_err), CNT_MAX));
              rsp_id    <= cur_id;
              rsp_prod  <= p1;
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4u_redundant_sched.sv
// Scoreboard bench for mult4u_redundant_sched with an attached multiplier model and fault injection.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low.
module tb_mult4u_redundant_sched;

  localparam int W         = 4;
  localparam int NREQ      = 2;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 8;
  localparam int SAT       = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic [W-1:0]        mult_a;
  logic [W-1:0]        mult_b;
  logic [2*W-1:0]      mult_p;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [0:0]          rsp_id;
  logic [2*W-1:0]      rsp_prod;
  logic                rsp_err;
  logic [CNT_W-1:0]    stat_mismatch;
  logic [CNT_W-1:0]    stat_err;

  always #5 clk = ~clk;

  mult4u_redundant_sched #(
    .W(W), .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_prod(rsp_prod), .rsp_err(rsp_err),
    .stat_mismatch(stat_mismatch), .stat_err(stat_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier model with fault injection.
  // kind 1: flip bit 0 the first time the operand pair (tr_a,tr_b) is driven, once per arming.
  // kind 2: bit 0 stuck at 1 whenever mult_a equals fa.
  int         fault_kind = 0;
  logic [3:0] fa = 4'h0;
  logic [3:0] tr_a = 4'h0;
  logic [3:0] tr_b = 4'h0;
  int         tr_hits = 0;
  int         tr_limit = 0;

  always_comb begin
    mult_p = {4'b0, mult_a} * {4'b0, mult_b};
    if (fault_kind == 1 && tr_hits < tr_limit && mult_a == tr_a && mult_b == tr_b) mult_p = mult_p ^ 8'h01;
    if (fault_kind == 2 && mult_a == fa) mult_p = mult_p | 8'h01;
  end

  always @(posedge clk)
    if (fault_kind == 1 && tr_hits < tr_limit && mult_a == tr_a && mult_b == tr_b) tr_hits <= tr_hits + 1;

  // Reference model state.
  typedef struct {
    int         id;
    logic [7:0] prod;
    bit         err;
    int         lat;
    int         hs;
    int         smis;
    int         serr;
  } exp_t;

  exp_t sbq[$];
  int   m_ptr  = 0;
  bit   m_idle = 1'b1;
  int   m_smis = 0;
  int   m_serr = 0;
  bit   resp_seen = 1'b0;
  bit   rsp_done  = 1'b0;

  function automatic logic [7:0] faulty(input logic [3:0] x, input logic [3:0] y, input int k);
    logic [7:0] p;
    p = {4'b0, x} * {4'b0, y};
    if (fault_kind == 1 && k == 0 && x == tr_a && y == tr_b) p = p ^ 8'h01;
    if (fault_kind == 2 && x == fa) p = p | 8'h01;
    return p;
  endfunction

  function automatic int rr_model(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic push_txn(input int w);
    exp_t       e;
    logic [3:0] a, b;
    logic [7:0] q1, q2;
    int         mism;
    mism  = 0;
    a     = req_a[w*W +: W];
    b     = req_b[w*W +: W];
    e.err = 1'b1;
    e.prod = 8'h00;
    for (int k = 0; k <= MAX_RETRY; k++) begin
      q1 = faulty(a, b, k);
      q2 = faulty(b, a, k);
      e.prod = q1;
      if (q1 == q2) begin
        e.err = 1'b0;
        break;
      end
      mism++;
    end
    e.lat  = 4 + 3 * ((mism > MAX_RETRY) ? MAX_RETRY : mism);
    m_smis = (m_smis + mism > SAT) ? SAT : m_smis + mism;
    m_serr = (m_serr + int'(e.err) > SAT) ? SAT : m_serr + int'(e.err);
    e.id   = w;
    e.hs   = cyc;
    e.smis = m_smis;
    e.serr = m_serr;
    sbq.push_back(e);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rsp_done) begin
      m_idle   = 1'b1;
      rsp_done = 1'b0;
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sbq.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        if (!resp_seen) begin
          chk("latency", cyc - sbq[0].hs, sbq[0].lat);
          chk("stat_mismatch", 32'(stat_mismatch), sbq[0].smis);
          chk("stat_err", 32'(stat_err), sbq[0].serr);
          resp_seen = 1'b1;
        end
        chk("rsp_id", 32'(rsp_id), sbq[0].id);
        chk("rsp_prod", 32'(rsp_prod), 32'(sbq[0].prod));
        chk("rsp_err", 32'(rsp_err), 32'(sbq[0].err));
        if (rsp_ready) begin
          void'(sbq.pop_front());
          resp_seen = 1'b0;
          rsp_done  = 1'b1;
        end
      end
    end
  end

  task automatic load(input int i, input bit on, input bit fixed, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]     = on;
    req_a[i*W +: W]  = fixed ? a : 4'($urandom_range(0, 15));
    req_b[i*W +: W]  = fixed ? b : 4'($urandom_range(0, 15));
  endtask

  // Issue n0/n1 requests on requesters 0/1; checks each grant against the round-robin model.
  task automatic issue(input int n0, input int n1, input bit fixed, input logic [3:0] a, input logic [3:0] b);
    int         left[2];
    int         spent;
    int         w;
    logic [1:0] acc;
    left[0] = n0;
    left[1] = n1;
    spent   = 0;
    for (int i = 0; i < NREQ; i++) load(i, left[i] > 0, fixed, a, b);
    while ((left[0] + left[1]) > 0 && spent < 50000) begin
      @(negedge clk);
      spent++;
      acc = 2'b00;
      if (m_idle && req_valid != 0) begin
        w = rr_model(req_valid, m_ptr);
        chk("grant", 32'(req_ready), 32'(1) << w);
        push_txn(w);
        left[w]--;
        acc[w] = 1'b1;
        m_ptr  = (w + 1) % NREQ;
        m_idle = 1'b0;
      end else begin
        chk("no_grant", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) load(i, left[i] > 0, fixed, a, b);
    end
    chk("issue_timeout", left[0] + left[1], 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !m_idle) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", sbq.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_mult_a"}, 32'(mult_a), 32'd0);
    chk({tag, "_mult_b"}, 32'(mult_b), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    chk({tag, "_rsp_prod"}, 32'(rsp_prod), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_stat_mismatch"}, 32'(stat_mismatch), 32'd0);
    chk({tag, "_stat_err"}, 32'(stat_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 2'b01;
    req_a     = 8'h00;
    req_b     = 8'h00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    @(posedge clk); #1;

    // Fault-free single transaction, 15*13.
    issue(1, 0, 1'b1, 4'hF, 4'hD);
    drain();

    // Both requesters hammering: grants must alternate.
    issue(4, 4, 1'b0, 4'h0, 4'h0);
    drain();

    // One-cycle corruption during the first swapped pass.
    fault_kind = 1;
    tr_a       = 4'h5;
    tr_b       = 4'h3;
    tr_limit   = tr_hits + 1;
    issue(1, 0, 1'b1, 4'h3, 4'h5);
    drain();
    fault_kind = 0;

    // Stuck bit whenever A is on the multiplier's A port: exhausts retries.
    fault_kind = 2;
    fa         = 4'h2;
    issue(0, 1, 1'b1, 4'h2, 4'h3);
    drain();
    fault_kind = 0;

    // Response backpressure: fields hold and no grant while held.
    rsp_ready = 1'b0;
    issue(1, 0, 1'b1, 4'h9, 4'h7);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_arrived", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_a     = 8'h21;
    req_b     = 8'h43;
    repeat (5) begin
      @(negedge clk);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    drain();

    // Reset in the middle of the second pass aborts everything.
    issue(1, 0, 1'b1, 4'h6, 4'h5);
    @(posedge clk); #2;
    chk("run2_mult_a", 32'(mult_a), 32'h5);
    chk("run2_mult_b", 32'(mult_b), 32'h6);
    req_valid = 2'b10;
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    sbq.delete();
    m_idle    = 1'b1;
    m_ptr     = 0;
    m_smis    = 0;
    m_serr    = 0;
    resp_seen = 1'b0;
    rsp_done  = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 2'b00;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Persistent errors to drive both counters into saturation.
    fault_kind = 2;
    fa         = 4'h2;
    issue(300, 0, 1'b1, 4'h2, 4'h3);
    drain();
    fault_kind = 0;
    chk("sat_stat_err", 32'(stat_err), SAT);
    chk("sat_stat_mismatch", 32'(stat_mismatch), SAT);

    // Clean random traffic afterwards; counters must stay pinned.
    issue(8, 8, 1'b0, 4'h0, 4'h0);
    drain();
    chk("final_stat_err", 32'(stat_err), SAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
